// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants and types for the async_fifo slice
package async_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;
    localparam int ADDR_W         = $clog2(DEPTH_DEF);
    localparam int CNT_W          = ADDR_W + 1;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/async_fifo_mem.sv
// rtl/async_fifo_mem.sv - DEPTH x DATA_WIDTH storage, sync write port, registered read port
module async_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: storage itself is never cleared, the pointers make stale data unreachable
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register cleared on reset and held when no read is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock FIFO with full/empty and error flags; ASYNC_FIFO_STICKY_ERR_EN makes errors sticky
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  write_error,
    output logic                  read_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_accept;
    logic          rd_accept;

    // Acceptance looks only at the registered flags, so a full FIFO still drains on w_en&&r_en
    always_comb begin
        full      = (count == FULL_COUNT);
        empty     = (count == '0);
        wr_accept = w_en && !full;
        rd_accept = r_en && !empty;
    end

    async_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept && !rst),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_accept),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: simultaneous accepted read and write leave it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ASYNC_FIFO_STICKY_ERR_EN
    // Sticky errors: once raised they stay set until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            write_error <= 1'b0;
            read_error  <= 1'b0;
        end else begin
            write_error <= write_error || (w_en && full);
            read_error  <= read_error  || (r_en && empty);
        end
    end
`else
    // Pulse errors: one cycle per offending request
    always_ff @(posedge clk) begin
        if (rst) begin
            write_error <= 1'b0;
            read_error  <= 1'b0;
        end else begin
            write_error <= w_en && full;
            read_error  <= r_en && empty;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - directed table-driven bench for async_fifo
module tb_async_fifo;

`ifdef ASYNC_FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       write_error;
    logic       read_error;

    int total = 0;
    int bad   = 0;

    bit exp_we_acc = 1'b0;
    bit exp_re_acc = 1'b0;

    always #5 clk = ~clk;

    async_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .r_en        (r_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .write_error (write_error),
        .read_error  (read_error)
    );

    typedef struct {
        logic [2:0] ctl;    // {rst, w_en, r_en}
        logic [7:0] din;
        logic [7:0] exp_d;
        logic [3:0] exp_f;  // {full, empty, write_error pulse, read_error pulse}
        string      name;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [2:0] c, input logic [7:0] d,
                                input logic [7:0] ed, input logic [3:0] ef, input string n);
        vec_t v;
        v.ctl = c; v.din = d; v.exp_d = ed; v.exp_f = ef; v.name = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge
    task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] d);
        rst = r; w_en = w; r_en = rd; data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Error flag model: pulse expectation folded into sticky accumulators when enabled
    task automatic chk_err(input string name, input bit rst_seen, input bit pw, input bit pr);
        if (rst_seen) begin
            exp_we_acc = 1'b0;
            exp_re_acc = 1'b0;
        end else if (STICKY) begin
            exp_we_acc = exp_we_acc | pw;
            exp_re_acc = exp_re_acc | pr;
        end else begin
            exp_we_acc = pw;
            exp_re_acc = pr;
        end
        chk({name, ".write_error"}, {31'b0, write_error}, {31'b0, exp_we_acc});
        chk({name, ".read_error"},  {31'b0, read_error},  {31'b0, exp_re_acc});
    endtask

    task automatic chk_flags(input string name, input bit f, input bit e);
        chk({name, ".full"},  {31'b0, full},  {31'b0, f});
        chk({name, ".empty"}, {31'b0, empty}, {31'b0, e});
    endtask

    initial begin
        logic [7:0] nw;
        logic [7:0] nr;

        vecs[0]  = mk(3'b100, 8'h00, 8'h00, 4'b0100, "reset0");
        vecs[1]  = mk(3'b100, 8'h00, 8'h00, 4'b0100, "reset1");
        vecs[2]  = mk(3'b010, 8'h11, 8'h00, 4'b0000, "wr11");
        vecs[3]  = mk(3'b010, 8'h22, 8'h00, 4'b0000, "wr22");
        vecs[4]  = mk(3'b010, 8'h33, 8'h00, 4'b0000, "wr33");
        vecs[5]  = mk(3'b001, 8'h00, 8'h11, 4'b0000, "rd11");
        vecs[6]  = mk(3'b001, 8'h00, 8'h22, 4'b0000, "rd22");
        vecs[7]  = mk(3'b001, 8'h00, 8'h33, 4'b0100, "rd33");
        vecs[8]  = mk(3'b001, 8'h00, 8'h33, 4'b0101, "underflow");
        vecs[9]  = mk(3'b000, 8'h00, 8'h33, 4'b0100, "idle");
        vecs[10] = mk(3'b011, 8'h44, 8'h33, 4'b0001, "wr_rd_empty");
        vecs[11] = mk(3'b001, 8'h00, 8'h44, 4'b0100, "rd44");

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].din);
            chk({vecs[i].name, ".data_out"}, {24'b0, data_out}, {24'b0, vecs[i].exp_d});
            chk_flags(vecs[i].name, vecs[i].exp_f[3], vecs[i].exp_f[2]);
            chk_err(vecs[i].name, vecs[i].ctl[2], vecs[i].exp_f[1], vecs[i].exp_f[0]);
        end

        // Fill to full, overflow, then full with both requests, then drain
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_err("fill_rst", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            chk_flags($sformatf("fill%0d", i), i == 15, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk_flags("overflow", 1'b1, 1'b0);
        chk_err("overflow", 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hBB);
        chk("full_wr_rd.data_out", {24'b0, data_out}, 32'h00);
        chk_flags("full_wr_rd", 1'b0, 1'b0);
        chk_err("full_wr_rd", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d.data_out", i), {24'b0, data_out}, i);
            chk_err($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b0);
        end
        chk_flags("drained", 1'b0, 1'b1);

        // Underflow keeps data_out and leaves count at zero
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("uf.data_out", {24'b0, data_out}, 32'h0F);
        chk_err("uf", 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_flags("uf_after", 1'b0, 1'b1);
        chk_err("uf_after", 1'b0, 1'b0, 1'b0);

        // Steady simultaneous traffic with 8 resident entries across pointer wrap
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_err("wrap_rst", 1'b1, 1'b0, 1'b0);
        nw = 8'h40;
        nr = 8'h40;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, nw);
            nw++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b1, nw);
            nw++;
            chk($sformatf("wrap%0d.data_out", i), {24'b0, data_out}, {24'b0, nr});
            nr++;
            chk_flags($sformatf("wrap%0d", i), 1'b0, 1'b0);
            chk_err($sformatf("wrap%0d", i), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk($sformatf("wrap_drain%0d.data_out", i), {24'b0, data_out}, {24'b0, nr});
            nr++;
        end
        chk_flags("wrap_drained", 1'b0, 1'b1);

        // Mid-operation reset with 5 entries and a prior error
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk_err("pre_rst_uf", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        end
        chk_flags("five_resident", 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_flags("mid_rst", 1'b0, 1'b1);
        chk("mid_rst.data_out", {24'b0, data_out}, 32'h00);
        chk_err("mid_rst", 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        chk_flags("post_rst_wr", 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_rst_rd.data_out", {24'b0, data_out}, 32'h5A);
        chk_flags("post_rst_rd", 1'b0, 1'b1);
        chk_err("post_rst_rd", 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
